async_fifo_wr_ctrl: RTL and testbench

//   Write-domain controller for the dual-clock FIFO. It replaces the bare write-pointer block with a parametrised depth and synchroniser length.

---
 rtl/async_fifo_wr_ctrl.sv | 88 ++++++++
 tb/tb_async_fifo_wr_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_wr_ctrl.sv
// rtl/async_fifo_wr_ctrl.sv - write-domain controller of the dual-clock FIFO
module async_fifo_wr_ctrl #(
    parameter int FIFO_DEPTH  = 16,
    parameter int ADDR_WIDTH  = $clog2(FIFO_DEPTH),
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  winc,
    input  logic                  wclr_ovf,
    input  logic [ADDR_WIDTH:0]   afull_thresh,
    input  logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  wen,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  wovf
);

    localparam int AW = ADDR_WIDTH;

    logic [AW:0] sync_q [SYNC_STAGES];
    logic [AW:0] wq_rptr;
    logic [AW:0] wq_rbin;
    logic [AW:0] wbin;
    logic [AW:0] wbin_nx;
    logic [AW:0] wgray_nx;
    logic [AW:0] lvl_nx;
    logic        full_nx;
    logic        afull_nx;

    // Read pointer crosses into this domain as Gray code, so only one bit can be in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wq_rptr = sync_q[SYNC_STAGES-1];

    always_comb begin
        wq_rbin = '0;
        for (int i = 0; i <= AW; i++) begin
            wq_rbin[i] = ^(wq_rptr >> i);
        end
    end

    assign wen      = winc & ~wfull;
    assign wbin_nx  = wbin + {{AW{1'b0}}, wen};
    assign wgray_nx = wbin_nx ^ (wbin_nx >> 1);
    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    assign full_nx  = (wgray_nx == {~wq_rptr[AW:AW-1], wq_rptr[AW-2:0]});
    assign lvl_nx   = wbin_nx - wq_rbin;
    assign afull_nx = (afull_thresh != '0) && (lvl_nx >= afull_thresh);
    assign waddr    = wbin[AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin         <= '0;
            wptr_gray    <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            wovf         <= 1'b0;
        end else begin
            wbin         <= wbin_nx;
            wptr_gray    <= wgray_nx;
            wfull        <= full_nx;
            walmost_full <= afull_nx;
            wlevel       <= lvl_nx;
            if (winc && wfull) begin
                wovf <= 1'b1;
            end else if (wclr_ovf) begin
                wovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// tb/tb_async_fifo_wr_ctrl.sv - randomized self-checking bench for async_fifo_wr_ctrl
module tb_async_fifo_wr_ctrl;

    localparam int SS = 2;

    logic       clk;
    logic       rst_n;
    logic       winc;
    logic       wclr_ovf;
    logic [4:0] thr;
    logic [4:0] rb;
    logic [4:0] rptr_gray;
    logic [4:0] wptr_gray;
    logic [3:0] waddr;
    logic       wen;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       wovf;

    int n_checks;
    int n_fail;

    // Reference model: totals of accepted writes and reads, read pointer seen SS edges late.
    int m_wtot;
    int rbin_tot;
    int m_level;
    bit m_full;
    bit m_afull;
    bit m_ovf;
    int rhist [SS];
    bit exp_wen;
    bit obs_wen;
    logic [3:0] exp_waddr;
    logic [3:0] obs_waddr;

    logic [15:0] dut_vec;

    assign rptr_gray = rb ^ (rb >> 1);
    assign dut_vec   = {wfull, walmost_full, wovf, wlevel, wptr_gray, waddr};

    async_fifo_wr_ctrl #(.FIFO_DEPTH(16), .SYNC_STAGES(SS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .winc         (winc),
        .wclr_ovf     (wclr_ovf),
        .afull_thresh (thr),
        .rptr_gray    (rptr_gray),
        .wptr_gray    (wptr_gray),
        .waddr        (waddr),
        .wen          (wen),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .wovf         (wovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [4:0] gray5(input int x);
        logic [4:0] b;
        b = x[4:0];
        return b ^ (b >> 1);
    endfunction

    function automatic logic [15:0] model_vec();
        logic [4:0] lv;
        logic [4:0] wb;
        lv = m_level[4:0];
        wb = m_wtot[4:0];
        return {m_full, m_afull, m_ovf, lv, gray5(m_wtot), wb[3:0]};
    endfunction

    task automatic model_reset();
        m_wtot = 0; rbin_tot = 0; m_level = 0;
        m_full = 0; m_afull = 0; m_ovf = 0;
        for (int i = 0; i < SS; i++) rhist[i] = 0;
        rb = 5'd0;
    endtask

    // Entered at posedge+1 with inputs already driven; leaves at the next posedge+1.
    task automatic step();
        int rs;
        int acc;
        logic [4:0] wb;
        #1;
        obs_wen   = wen;
        obs_waddr = waddr;
        wb        = m_wtot[4:0];
        acc       = (winc && !m_full) ? 1 : 0;
        exp_wen   = (acc == 1);
        exp_waddr = wb[3:0];
        rs        = rhist[SS-1];
        if (winc && m_full) m_ovf = 1;
        else if (wclr_ovf) m_ovf = 0;
        m_wtot  = m_wtot + acc;
        m_level = ((m_wtot % 32) - rs + 32) % 32;
        m_full  = (m_level == 16);
        m_afull = (thr != 0) && (m_level >= int'(thr));
        for (int i = SS - 1; i > 0; i--) rhist[i] = rhist[i-1];
        rhist[0] = int'(rb);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; winc = 1'b0; wclr_ovf = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; winc = 1'b0; wclr_ovf = 1'b0; thr = 5'd12;
        model_reset();
        #7;
        n_checks++;
        if ({wptr_gray, waddr, wfull, walmost_full, wlevel, wovf, wen} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=0", {wptr_gray, waddr, wfull, walmost_full, wlevel, wovf, wen});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fill(input logic [4:0] t);
        do_reset();
        thr = t;
        for (int i = 1; i <= 17; i++) begin
            winc = 1'b1;
            step();
            n_checks++;
            if (obs_wen !== exp_wen || obs_waddr !== exp_waddr) begin
                n_fail++;
                $display("FAIL fill_wen_waddr i=%0d got=%b/%0d want=%b/%0d", i, obs_wen, obs_waddr, exp_wen, exp_waddr);
            end
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL fill_state i=%0d got=%h want=%h", i, dut_vec, model_vec());
            end
            n_checks++;
            if (wfull !== (i >= 16) || walmost_full !== (t != 0 && i >= 12) || walmost_full === 1'bx) begin
                n_fail++;
                $display("FAIL fill_flags i=%0d got=%b%b want=%b%b", i, wfull, walmost_full, i >= 16, t != 0 && i >= 12);
            end
            if (i <= 16) begin
                n_checks++;
                if (obs_waddr !== 4'(i - 1)) begin
                    n_fail++;
                    $display("FAIL fill_addr i=%0d got=%0d want=%0d", i, obs_waddr, i - 1);
                end
            end
        end
        n_checks++;
        if (wptr_gray !== 5'b11000 || wlevel !== 5'd16 || obs_wen !== 1'b0 || wovf !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_end got=%b/%0d/%b/%b want=11000/16/0/1", wptr_gray, wlevel, obs_wen, wovf);
        end
    endtask

    task automatic test_drain();
        winc = 1'b0;
        rbin_tot = 4;
        rb = 5'd4;
        for (int k = 1; k <= 3; k++) begin
            step();
            n_checks++;
            if (wfull !== (k < 3) || dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL drain_edge k=%0d got=%h want=%h", k, dut_vec, model_vec());
            end
        end
        n_checks++;
        if (wlevel !== 5'd12 || walmost_full !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_level got=%0d/%b want=12/1", wlevel, walmost_full);
        end
        thr = 5'd13;
        step();
        n_checks++;
        if (walmost_full !== 1'b0 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL drain_thresh13 got=%h want=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_wrap();
        logic [4:0] prev;
        int writes;
        int guard;
        do_reset();
        thr = 5'd12;
        writes = 0;
        guard = 0;
        while (writes < 40 && guard < 400) begin
            guard++;
            winc = ($urandom_range(0, 3) != 0);
            prev = wptr_gray;
            step();
            n_checks++;
            if (dut_vec !== model_vec() || wfull !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_state w=%0d got=%h want=%h", writes, dut_vec, model_vec());
            end
            if (exp_wen) begin
                writes++;
                n_checks++;
                if ($countones(wptr_gray ^ prev) != 1 || (prev[4] != wptr_gray[4]) != (writes == 16 || writes == 32)) begin
                    n_fail++;
                    $display("FAIL wrap_gray w=%0d got=%b prev=%b want_hamming=1", writes, wptr_gray, prev);
                end
            end
            rbin_tot = (writes > 2) ? writes - 2 : 0;
            rb = rbin_tot[4:0];
        end
        n_checks++;
        if (writes != 40) begin
            n_fail++;
            $display("FAIL wrap_budget got=%0d want=40", writes);
        end
    endtask

    task automatic test_overflow_clear();
        int guard;
        guard = 0;
        winc = 1'b1;
        while (!m_full && guard < 40) begin
            guard++;
            step();
        end
        n_checks++;
        if (wfull !== 1'b1 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL ovf_fill got=%h want=%h", dut_vec, model_vec());
        end
        step();
        n_checks++;
        if (wovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set got=%b want=1", wovf);
        end
        wclr_ovf = 1'b1;
        step();
        n_checks++;
        if (wovf !== 1'b1 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL ovf_set_wins got=%b want=1", wovf);
        end
        winc = 1'b0;
        step();
        n_checks++;
        if (wovf !== 1'b0 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL ovf_clear got=%b want=0", wovf);
        end
        wclr_ovf = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        thr = 5'd12;
        winc = 1'b1;
        repeat (7) step();
        n_checks++;
        if (waddr !== 4'd7 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL midrst_pre got=%h want=%h", dut_vec, model_vec());
        end
        #3;
        rst_n = 1'b0;
        winc = 1'b0;
        #1;
        n_checks++;
        if ({wptr_gray, waddr, wfull, walmost_full, wlevel, wovf, wen} !== '0) begin
            n_fail++;
            $display("FAIL midrst_async got=%h want=0", {wptr_gray, waddr, wfull, walmost_full, wlevel, wovf, wen});
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        winc = 1'b1;
        step();
        n_checks++;
        if (obs_waddr !== 4'd0 || wlevel !== 5'd1 || obs_wen !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_first got=%0d/%0d want=0/1", obs_waddr, wlevel);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 0) thr = 5'($urandom_range(0, 20));
            winc     = ($urandom_range(0, 2) != 0);
            wclr_ovf = ($urandom_range(0, 15) == 0);
            if (rbin_tot < m_wtot && $urandom_range(0, 2) == 0) rbin_tot++;
            rb = rbin_tot[4:0];
            step();
            n_checks++;
            if (obs_wen !== exp_wen || obs_waddr !== exp_waddr || dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL random c=%0d got=%b/%h want=%b/%h", c, obs_wen, dut_vec, exp_wen, model_vec());
            end
        end
        wclr_ovf = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rb       = 5'd0;
        thr      = 5'd12;
        test_reset();
        test_fill(5'd12);
        test_drain();
        test_wrap();
        test_overflow_clear();
        test_reset_mid();
        test_fill(5'd0);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
